// File: rtl/sync_fifo_monitor.sv
// ---------------------------------------------------------------------------
// sync_fifo_monitor
//
// Shadow-model checker that sits beside a synchronous FIFO. It keeps its own
// reference queue of everything the FIFO accepted. Every cycle it checks the
// FIFO's empty/full flags and read data against that queue.
//
// Parameters
//   WIDTH       data width of wData/rdData
//   DEPTH       FIFO capacity in entries (power of two, >= 2)
//   RD_LATENCY  0 = show-ahead read data, 1 = read data one cycle after read
//   CNT_W       width of the saturating error-cycle counter
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   write, read  FIFO write / read strobes
//   wData        FIFO write data
//   rdData       FIFO read data
//   empty, full  FIFO status flags
//   err_clr      clears err_sticky and err_count (model untouched)
//   err_now      errors seen this cycle (combinational, 0 during reset)
//                  [0] empty mismatch     [1] full mismatch
//                  [2] empty and full     [3] read data mismatch
//                  [4] overflow attempt   [5] underflow attempt
//   err_sticky   OR-accumulation of err_now
//   err_count    number of cycles with any error, saturating
//   model_count  reference queue occupancy
//   peak_count   highest occupancy since reset
//   wr_total     accepted writes (wraps)
//   rd_total     accepted reads (wraps)
//
// Optional build macro
//   SYNC_FIFO_MONITOR_DISPLAY_EN  when defined, prints a line on every error
//                                 cycle and raises an assertion on a read
//                                 data mismatch (simulation only)
// ---------------------------------------------------------------------------
module sync_fifo_monitor #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 0,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write,
    input  logic                         read,
    input  logic [WIDTH-1:0]             wData,
    input  logic [WIDTH-1:0]             rdData,
    input  logic                         empty,
    input  logic                         full,
    input  logic                         err_clr,
    output logic [5:0]                   err_now,
    output logic [5:0]                   err_sticky,
    output logic [CNT_W-1:0]             err_count,
    output logic [$clog2(DEPTH+1)-1:0]   model_count,
    output logic [$clog2(DEPTH+1)-1:0]   peak_count,
    output logic [31:0]                  wr_total,
    output logic [31:0]                  rd_total
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    localparam int E_EMPTY     = 0;
    localparam int E_FULL      = 1;
    localparam int E_BOTH      = 2;
    localparam int E_DATA      = 3;
    localparam int E_OVERFLOW  = 4;
    localparam int E_UNDERFLOW = 5;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [OW-1:0]    count;
    logic [OW-1:0]    count_nxt;
    logic             is_empty;
    logic             is_full;
    logic             acc_wr;
    logic             acc_rd;
    logic [WIDTH-1:0] head_data;
    logic             cmp_valid;
    logic [WIDTH-1:0] cmp_exp;
    logic             data_err;

    assign is_empty  = (count == '0);
    assign is_full   = (count == DEPTH_C);
    assign head_data = mem[head];

    // A read is only honoured when the model holds data. A write is honoured
    // when there is room, or when the model is full but a read frees the
    // head slot in the same cycle.
    assign acc_rd = read && !is_empty;
    assign acc_wr = write && (!is_full || read);

    assign model_count = count;

    // Occupancy after this cycle's accepted traffic.
    always_comb begin
        count_nxt = count + OW'(acc_wr) - OW'(acc_rd);
    end

    // Where and when read data is compared depends on the FIFO's read latency.
    // Show-ahead FIFOs present the head during the read cycle. Registered-read
    // FIFOs present it one cycle later, so the expected head is held
    // in a one-deep pipeline that reset invalidates.
    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign cmp_valid = acc_rd;
            assign cmp_exp   = head_data;
        end else begin : g_lat1
            logic             pend_valid;
            logic [WIDTH-1:0] pend_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_valid <= 1'b0;
                    pend_data  <= '0;
                end else begin
                    pend_valid <= acc_rd;
                    if (acc_rd) begin
                        pend_data <= head_data;
                    end
                end
            end

            assign cmp_valid = pend_valid;
            assign cmp_exp   = pend_data;
        end
    endgenerate

    // Case inequality so an X on rdData counts as a data mismatch in simulation.
    assign data_err = cmp_valid && (rdData !== cmp_exp);

    // Per-cycle error vector from the registered model state and this
    // cycle's inputs. The vector is held at zero while reset is asserted.
    always_comb begin
        err_now = '0;
        if (!rst) begin
            err_now[E_EMPTY]     = (empty != is_empty);
            err_now[E_FULL]      = (full != is_full);
            err_now[E_BOTH]      = empty && full;
            err_now[E_DATA]      = data_err;
            err_now[E_OVERFLOW]  = write && is_full && !read;
            err_now[E_UNDERFLOW] = read && is_empty;
        end
    end

    // Reference queue storage. The array has no reset. Reset clears the
    // pointers and the count, which is enough to make the queue empty.
    always_ff @(posedge clk) begin
        if (!rst && acc_wr) begin
            mem[tail] <= wData;
        end
    end

    // Queue pointers, occupancy, peak occupancy and traffic counters.
    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            peak_count <= '0;
            wr_total   <= '0;
            rd_total   <= '0;
        end else begin
            if (acc_wr) begin
                tail     <= tail + AW'(1);
                wr_total <= wr_total + 32'd1;
            end
            if (acc_rd) begin
                head     <= head + AW'(1);
                rd_total <= rd_total + 32'd1;
            end
            count <= count_nxt;
            if (count_nxt > peak_count) begin
                peak_count <= count_nxt;
            end
        end
    end

    // Sticky error bits and the saturating error-cycle counter. A clear
    // takes priority, so errors seen in the clear cycle are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= '0;
            err_count  <= '0;
        end else if (err_clr) begin
            err_sticky <= '0;
            err_count  <= '0;
        end else begin
            err_sticky <= err_sticky | err_now;
            if ((err_now != '0) && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

`ifdef SYNC_FIFO_MONITOR_DISPLAY_EN
    // Simulation-only reporting. It has no effect on any output.
    always_ff @(posedge clk) begin
        if (err_now != '0) begin
            $display("[SVA] sync_fifo_monitor err=%b cnt=%0d full=%b empty=%b exp=%h got=%h",
                     err_now, count, full, empty, cmp_exp, rdData);
        end
        if (!rst) begin
            assert (!data_err)
            else $error("sync_fifo_monitor read data error: exp=%h got=%h", cmp_exp, rdData);
        end
    end
`else
`endif

endmodule

// File: tb/tb_sync_fifo_monitor.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_monitor
//
// Directed bench for sync_fifo_monitor. The bench plays the FIFO itself.
// Written data goes into a reference queue, and reads present data popped
// from it, with deliberate corruption on selected reads. The expected err_now
// for each driven cycle is pushed to a queue and popped when the combinational
// output is sampled.
// Two monitors are exercised:
//   dut0: DEPTH=4, RD_LATENCY=0, CNT_W=4 (show-ahead, small saturating count)
//   dut1: DEPTH=4, RD_LATENCY=1, CNT_W=16 (registered read data)
// ---------------------------------------------------------------------------
module tb_sync_fifo_monitor;

    localparam int W = 8;

    logic clk;
    logic rst;

    logic         w0, r0, e0, f0, clr0;
    logic [W-1:0] wd0, rd0;
    logic [5:0]   en0, es0;
    logic [3:0]   ec0;
    logic [2:0]   mc0, pk0;
    logic [31:0]  wt0, rt0;

    logic         w1, r1, e1, f1, clr1;
    logic [W-1:0] wd1, rd1;
    logic [5:0]   en1, es1;
    logic [15:0]  ec1;
    logic [2:0]   mc1, pk1;
    logic [31:0]  wt1, rt1;

    int errors = 0;
    int checks = 0;

    logic [5:0]   exp_q[$];
    logic [W-1:0] ref0_q[$];
    logic [W-1:0] ref1_q[$];
    logic [W-1:0] d;
    logic [W-1:0] pend1;

    sync_fifo_monitor #(.WIDTH(W), .DEPTH(4), .RD_LATENCY(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .write(w0), .read(r0), .wData(wd0), .rdData(rd0),
        .empty(e0), .full(f0), .err_clr(clr0), .err_now(en0), .err_sticky(es0),
        .err_count(ec0), .model_count(mc0), .peak_count(pk0),
        .wr_total(wt0), .rd_total(rt0)
    );

    sync_fifo_monitor #(.WIDTH(W), .DEPTH(4), .RD_LATENCY(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .write(w1), .read(r1), .wData(wd1), .rdData(rd1),
        .empty(e1), .full(f1), .err_clr(clr1), .err_now(en1), .err_sticky(es1),
        .err_count(ec1), .model_count(mc1), .peak_count(pk1),
        .wr_total(wt1), .rd_total(rt1)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upper bound on run time in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point with failure accounting.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pops the expected err_now for the current cycle and compares it.
    task automatic checkOutput(input int which, input string tag);
        logic [5:0] exp;
        exp = exp_q.pop_front();
        checkVal(tag, (which == 0) ? {26'd0, en0} : {26'd0, en1}, {26'd0, exp});
    endtask

    // Drives one cycle of stimulus to the selected monitor on the falling
    // edge, records its expected err_now and samples it before the next
    // rising edge.
    task automatic applyStimulus(input int which, input string tag, input logic rs,
                                 input logic w, input logic r,
                                 input logic [W-1:0] wd, input logic [W-1:0] rd,
                                 input logic e, input logic f, input logic clr,
                                 input logic [5:0] exp_err);
        @(negedge clk);
        rst = rs;
        if (which == 0) begin
            w0 = w; r0 = r; wd0 = wd; rd0 = rd; e0 = e; f0 = f; clr0 = clr;
        end else begin
            w1 = w; r1 = r; wd1 = wd; rd1 = rd; e1 = e; f1 = f; clr1 = clr;
        end
        exp_q.push_back(exp_err);
        #1;
        checkOutput(which, tag);
    endtask

    // Lets the pending rising edge update registered state.
    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        w0 = 0; r0 = 0; wd0 = '0; rd0 = '0; e0 = 1; f0 = 0; clr0 = 0;
        w1 = 0; r1 = 0; wd1 = '0; rd1 = '0; e1 = 1; f1 = 0; clr1 = 0;
        pend1 = '0;

        // Reset
        applyStimulus(0, "rst_err_now", 1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 6'b000000);
        afterEdge();
        checkVal("rst_model_count", {29'd0, mc0}, 32'd0);
        checkVal("rst_peak_count", {29'd0, pk0}, 32'd0);
        checkVal("rst_err_count", {28'd0, ec0}, 32'd0);
        checkVal("rst_err_sticky", {26'd0, es0}, 32'd0);
        checkVal("rst_wr_total", wt0, 32'd0);
        checkVal("rst_rd_total", rt0, 32'd0);
        checkVal("rst1_model_count", {29'd0, mc1}, 32'd0);

        // Fill to capacity with correct flags
        for (int i = 0; i < 4; i++) begin
            d = W'((i + 1) * 17);
            ref0_q.push_back(d);
            applyStimulus(0, "fill_err_now", 0, 1, 0, d, 8'h00, (i == 0), 0, 0, 6'b000000);
        end
        afterEdge();
        checkVal("fill_model_count", {29'd0, mc0}, 32'd4);
        checkVal("fill_peak_count", {29'd0, pk0}, 32'd4);
        checkVal("fill_err_sticky", {26'd0, es0}, 32'd0);
        checkVal("fill_wr_total", wt0, 32'd4);
        applyStimulus(0, "full_idle_err_now", 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 6'b000000);

        // Drain, third read returns corrupted data (0x33 -> 0x99)
        for (int k = 0; k < 4; k++) begin
            d = ref0_q.pop_front();
            applyStimulus(0, "drain_err_now", 0, 0, 1, 8'h00, (k == 2) ? (d ^ 8'hAA) : d,
                          0, (k == 0), 0, (k == 2) ? 6'b001000 : 6'b000000);
        end
        afterEdge();
        checkVal("drain_err_count", {28'd0, ec0}, 32'd1);
        checkVal("drain_err_sticky", {26'd0, es0}, 32'b001000);
        checkVal("drain_model_count", {29'd0, mc0}, 32'd0);
        checkVal("drain_rd_total", rt0, 32'd4);

        // Refill, then wrong full flag and an overflow attempt
        for (int i = 0; i < 4; i++) begin
            d = W'(8'h55 + (i * 17));
            ref0_q.push_back(d);
            applyStimulus(0, "refill_err_now", 0, 1, 0, d, 8'h00, (i == 0), 0, 0, 6'b000000);
        end
        applyStimulus(0, "full_flag_err_now", 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 6'b000010);
        applyStimulus(0, "overflow_err_now", 0, 1, 0, 8'hEE, 8'h00, 0, 1, 0, 6'b010000);
        afterEdge();
        checkVal("overflow_model_count", {29'd0, mc0}, 32'd4);
        checkVal("overflow_wr_total", wt0, 32'd8);

        // Simultaneous read and write while full
        d = ref0_q.pop_front();
        ref0_q.push_back(8'h99);
        applyStimulus(0, "rw_full_err_now", 0, 1, 1, 8'h99, d, 0, 1, 0, 6'b000000);
        afterEdge();
        checkVal("rw_full_model_count", {29'd0, mc0}, 32'd4);
        checkVal("rw_full_wr_total", wt0, 32'd9);
        checkVal("rw_full_rd_total", rt0, 32'd5);
        checkVal("rw_full_err_count", {28'd0, ec0}, 32'd3);
        checkVal("rw_full_err_sticky", {26'd0, es0}, 32'b011010);

        // Both flags asserted, then a clear whose own errors are dropped
        applyStimulus(0, "both_err_now", 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 6'b000101);
        afterEdge();
        checkVal("both_err_sticky", {26'd0, es0}, 32'b011111);
        checkVal("both_err_count", {28'd0, ec0}, 32'd4);
        applyStimulus(0, "clr_err_now", 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 6'b000101);
        afterEdge();
        checkVal("clr_err_sticky", {26'd0, es0}, 32'd0);
        checkVal("clr_err_count", {28'd0, ec0}, 32'd0);
        checkVal("clr_model_count", {29'd0, mc0}, 32'd4);

        // Saturation: 2^4 + 5 error cycles
        for (int i = 0; i < 21; i++) begin
            applyStimulus(0, "sat_err_now", 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 6'b000101);
        end
        afterEdge();
        checkVal("sat_err_count", {28'd0, ec0}, 32'h0000000F);
        checkVal("sat_err_sticky", {26'd0, es0}, 32'b000101);

        // Drain remaining entries correctly, then underflow
        for (int k = 0; k < 4; k++) begin
            d = ref0_q.pop_front();
            applyStimulus(0, "drain2_err_now", 0, 0, 1, 8'h00, d, 0, (k == 0), 0, 6'b000000);
        end
        applyStimulus(0, "underflow_err_now", 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 6'b100000);
        afterEdge();
        checkVal("underflow_model_count", {29'd0, mc0}, 32'd0);
        checkVal("underflow_rd_total", rt0, 32'd9);
        checkVal("underflow_peak_count", {29'd0, pk0}, 32'd4);
        applyStimulus(0, "idle0_err_now", 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 6'b000000);

        // Registered-read monitor: two writes, then read+write at count 2
        for (int i = 0; i < 2; i++) begin
            d = W'(8'hA1 + i);
            ref1_q.push_back(d);
            applyStimulus(1, "l1_fill_err_now", 0, 1, 0, d, 8'h00, (i == 0), 0, 0, 6'b000000);
        end
        pend1 = ref1_q.pop_front();
        ref1_q.push_back(8'hA3);
        applyStimulus(1, "l1_rw_err_now", 0, 1, 1, 8'hA3, 8'h00, 0, 0, 0, 6'b000000);
        applyStimulus(1, "l1_cmp_ok_err_now", 0, 0, 0, 8'h00, pend1, 0, 0, 0, 6'b000000);
        afterEdge();
        checkVal("l1_rw_model_count", {29'd0, mc1}, 32'd2);
        checkVal("l1_rw_wr_total", wt1, 32'd3);
        checkVal("l1_rw_rd_total", rt1, 32'd1);
        checkVal("l1_rw_err_sticky", {26'd0, es1}, 32'd0);

        // Delayed compare catches bad data
        pend1 = ref1_q.pop_front();
        applyStimulus(1, "l1_rd_err_now", 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 6'b000000);
        applyStimulus(1, "l1_cmp_bad_err_now", 0, 0, 0, 8'h00, pend1 ^ 8'hFF, 0, 0, 0, 6'b001000);

        // Read, then reset before its compare: no data error
        pend1 = ref1_q.pop_front();
        applyStimulus(1, "l1_rd2_err_now", 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 6'b000000);
        afterEdge();
        checkVal("l1_pre_rst_err_sticky", {26'd0, es1}, 32'b001000);
        checkVal("l1_pre_rst_err_count", {16'd0, ec1}, 32'd1);
        checkVal("l1_pre_rst_model_count", {29'd0, mc1}, 32'd0);
        applyStimulus(1, "l1_rst_err_now", 1, 0, 0, 8'h00, pend1 ^ 8'hFF, 1, 0, 0, 6'b000000);
        afterEdge();
        checkVal("l1_rst_wr_total", wt1, 32'd0);
        checkVal("l1_rst_rd_total", rt1, 32'd0);
        checkVal("l1_rst_err_count", {16'd0, ec1}, 32'd0);
        checkVal("l1_rst_peak_count", {29'd0, pk1}, 32'd0);
        applyStimulus(1, "l1_post_rst_err_now", 0, 0, 0, 8'h00, pend1 ^ 8'hFF, 1, 0, 0, 6'b000000);
        afterEdge();
        checkVal("l1_post_rst_err_sticky", {26'd0, es1}, 32'd0);
        checkVal("l1_post_rst_model_count", {29'd0, mc1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
